csa_pipe_adder: RTL and testbench

//  Parametrised, pipelined carry-skip adder for the three-tap filter datapath.

---
 rtl/csa_pkg.sv | 46 ++++
 rtl/csa_skip_group.sv | 32 +++
 rtl/csa_pipe_adder.sv | 154 +++++++++++++++
 tb/tb_csa_pipe_adder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared constants and helpers for the pipelined carry-skip adder.
// Segment sizing functions are used at elaboration time only.
package csa_pkg;

  localparam int unsigned CSA_WIDTH = 16;
  localparam int unsigned CSA_BLK   = 4;

  // Boundary-register layout at the default width.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [CSA_WIDTH-1:0] psum;
    logic [CSA_WIDTH-1:0] a;
    logic [CSA_WIDTH-1:0] b;
  } csa_stage_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) begin
      r++;
    end
    return r;
  endfunction

  // Groups per segment for every segment except possibly the last.
  function automatic int unsigned csa_seg_size(input int unsigned g, input int unsigned pipe);
    return (g + pipe - 1) / pipe;
  endfunction

  // Segment s takes a full share; the last populated segment takes what is left.
  function automatic int unsigned csa_seg_groups(input int unsigned g, input int unsigned pipe,
                                                 input int unsigned s);
    int unsigned sz;
    int unsigned first;
    sz    = csa_seg_size(g, pipe);
    first = s * sz;
    if (first >= g) begin
      return 0;
    end else if (g - first < sz) begin
      return g - first;
    end
    return sz;
  endfunction

endpackage

// File: rtl/csa_skip_group.sv
// One carry-skip group: ripple sum inside the group, carry-in bypass when every
// bit propagates. Purely combinational.
module csa_skip_group
  import csa_pkg::*;
#(
  parameter int unsigned BLK = CSA_BLK
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           co,
  output logic           P
);

  logic [BLK-1:0] p;
  logic [BLK-1:0] g;
  logic [BLK:0]   c;

  assign p    = a ^ b;
  assign g    = a & b;
  assign c[0] = ci;

  for (genvar i = 0; i < BLK; i++) begin : g_bit
    assign c[i+1] = g[i] | (p[i] & c[i]);
  end

  assign s  = p ^ c[BLK-1:0];
  assign P  = &p;
  assign co = P ? ci : c[BLK];

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-skip adder with valid/ready on both sides and a global stall.
// Optional signed clamp on the final stage: define CSA_PIPE_ADDER_SAT_EN.
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = CSA_WIDTH,
  parameter int unsigned BLK   = CSA_BLK,
  parameter int unsigned PIPE  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned G   = WIDTH / BLK;
  localparam int unsigned SEG = csa_seg_size(G, PIPE);
  localparam int unsigned L   = PIPE - 1;

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t           seg_in    [PIPE];
  logic [WIDTH-1:0] seg_psum  [PIPE];
  logic             seg_carry [PIPE];

  logic [BLK-1:0]   grp_s  [G];
  logic             grp_co [G];
  logic [G-1:0]     unused_grp_p;

  logic             advance;

  // A full stall freezes every stage; bubbles are never squeezed out.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !rst;

  assign seg_in[0].valid = in_valid;
  assign seg_in[0].carry = cin;
  assign seg_in[0].psum  = '0;
  assign seg_in[0].a     = a;
  assign seg_in[0].b     = b;

  for (genvar k = 0; k < G; k++) begin : g_grp
    localparam int unsigned S     = k / SEG;
    localparam int unsigned FIRST = S * SEG;
    logic ci;

    // The first group of a segment takes its carry from the boundary register.
    if (k == FIRST) begin : g_head
      assign ci = seg_in[S].carry;
    end else begin : g_chain
      assign ci = grp_co[k-1];
    end

    csa_skip_group #(
      .BLK(BLK)
    ) u_grp (
      .a (seg_in[S].a[k*BLK +: BLK]),
      .b (seg_in[S].b[k*BLK +: BLK]),
      .ci(ci),
      .s (grp_s[k]),
      .co(grp_co[k]),
      .P (unused_grp_p[k])
    );
  end

  for (genvar s = 0; s < PIPE; s++) begin : g_seg
    localparam int unsigned NG    = csa_seg_groups(G, PIPE, s);
    localparam int unsigned FIRST = s * SEG;

    for (genvar k = 0; k < G; k++) begin : g_slice
      if (k >= FIRST && k < FIRST + NG) begin : g_new
        assign seg_psum[s][k*BLK +: BLK] = grp_s[k];
      end else begin : g_keep
        assign seg_psum[s][k*BLK +: BLK] = seg_in[s].psum[k*BLK +: BLK];
      end
    end

    if (NG > 0) begin : g_co
      assign seg_carry[s] = grp_co[FIRST+NG-1];
    end else begin : g_pass
      assign seg_carry[s] = seg_in[s].carry;
    end

    if (s < PIPE - 1) begin : g_bnd
      stage_t bnd_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          bnd_q <= '0;
        end else if (advance) begin
          bnd_q.valid <= seg_in[s].valid;
          bnd_q.carry <= seg_carry[s];
          bnd_q.psum  <= seg_psum[s];
          bnd_q.a     <= seg_in[s].a;
          bnd_q.b     <= seg_in[s].b;
        end
      end

      assign seg_in[s+1] = bnd_q;
    end
  end

  logic             a_msb;
  logic             b_msb;
  logic             ovf_d;
  logic [WIDTH-1:0] sum_d;

  assign a_msb = seg_in[L].a[WIDTH-1];
  assign b_msb = seg_in[L].b[WIDTH-1];
  assign ovf_d = (a_msb == b_msb) && (seg_psum[L][WIDTH-1] != a_msb);

`ifdef CSA_PIPE_ADDER_SAT_EN
  always_comb begin
    sum_d = seg_psum[L];
    if (ovf_d) begin
      sum_d = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign sum_d = seg_psum[L];
`endif

  // Result fields only load with a valid set so they keep the last value otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (advance) begin
      out_valid <= seg_in[L].valid;
      if (seg_in[L].valid) begin
        sum  <= sum_d;
        cout <= seg_carry[L];
        ovf  <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Scoreboarded bench: a PIPE=2 adder for directed flow-control cases, plus PIPE=1
// and PIPE=4 adders that join the random phase with latency tracking.
module tb_csa_pipe_adder;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int unsigned  stamp;
  } sb_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         iv   [3];
  logic         ir   [3];
  logic         ov   [3];
  logic         ordy [3];
  logic [W-1:0] sm   [3];
  logic         co   [3];
  logic         of   [3];
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;

  int unsigned  checks = 0;
  int unsigned  errors = 0;
  int unsigned  cyc = 0;
  int unsigned  nout [3] = '{0, 0, 0};
  int unsigned  pipe_of [3] = '{2, 1, 4};
  sb_t          sbq [3][$];
  sb_t          e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  csa_pipe_adder #(.WIDTH(W), .BLK(4), .PIPE(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a), .b(b), .cin(cin),
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sm[0]), .cout(co[0]), .ovf(of[0])
  );

  csa_pipe_adder #(.WIDTH(W), .BLK(4), .PIPE(1)) u_dut_p1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a), .b(b), .cin(cin),
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sm[1]), .cout(co[1]), .ovf(of[1])
  );

  csa_pipe_adder #(.WIDTH(W), .BLK(4), .PIPE(4)) u_dut_p4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a), .b(b), .cin(cin),
    .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sm[2]), .cout(co[2]), .ovf(of[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic sb_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                                input int unsigned st);
    logic [W:0] full;
    sb_t        r;
    full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
`ifdef CSA_PIPE_ADDER_SAT_EN
    if (r.ovf) r.sum = x[W-1] ? 16'h8000 : 16'h7fff;
`endif
    r.stamp = st;
    return r;
  endfunction

  // Pop on an output handshake, push on an input handshake; reset empties everything.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) sbq[i].delete();
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (ov[i] && ordy[i]) begin
          nout[i]++;
          check($sformatf("sb_nonempty%0d", i), (sbq[i].size() > 0), 1);
          if (sbq[i].size() > 0) begin
            e = sbq[i].pop_front();
            check($sformatf("sb_sum%0d", i), sm[i], e.sum);
            check($sformatf("sb_cout%0d", i), co[i], e.cout);
            check($sformatf("sb_ovf%0d", i), of[i], e.ovf);
            if (i > 0) check($sformatf("sb_latency%0d", i), cyc - e.stamp, pipe_of[i]);
          end
        end
        if (iv[i] && ir[i]) sbq[i].push_back(model(a, b, cin, cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int   n;
    logic acc;
    n     = 0;
    acc   = 1'b0;
    a     = x;
    b     = y;
    cin   = c;
    iv[0] = 1'b1;
    do begin
      @(negedge clk);
      acc = ir[0];
      tick();
      n++;
    end while (!acc && n < 50);
    iv[0] = 1'b0;
    check("send_accept", acc, 1);
  endtask

  task automatic run_one(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input logic [W-1:0] es, input logic ec,
                         input logic eo);
    int unsigned lat;
    send(x, y, c);
    lat = 1;
    while (!ov[0] && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 2);
    check({tag, "_sum"}, sm[0], es);
    check({tag, "_cout"}, co[0], ec);
    check({tag, "_ovf"}, of[0], eo);
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned base;
    int unsigned base1;
    int unsigned base2;
    int unsigned sent;

    rst = 1'b1;
    a   = '0;
    b   = '0;
    cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i]   = 1'b0;
      ordy[i] = 1'b1;
    end
    #1;
    check("rst_out_valid", ov[0], 0);
    check("rst_sum", sm[0], 0);
    check("rst_cout", co[0], 0);
    check("rst_ovf", of[0], 0);
    check("rst_out_valid_p1", ov[1], 0);
    check("rst_out_valid_p4", ov[2], 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("idle_in_ready", ir[0], 1);
    tick();

    run_one("t1", 16'hffff, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("t2", 16'hffff, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
`ifdef CSA_PIPE_ADDER_SAT_EN
    run_one("t3_pos", 16'h7fff, 16'h0001, 1'b0, 16'h7fff, 1'b0, 1'b1);
    run_one("t3_neg", 16'h8000, 16'hffff, 1'b0, 16'h8000, 1'b1, 1'b1);
`else
    run_one("t3_pos", 16'h7fff, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("t3_neg", 16'h8000, 16'hffff, 1'b0, 16'h7fff, 1'b1, 1'b1);
`endif
    run_one("t_cin", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);

    base = nout[0];
    fork
      begin
        send(16'h0001, 16'h0001, 1'b0);
        send(16'h1234, 16'h4321, 1'b0);
        send(16'h00ff, 16'h0001, 1'b0);
        send(16'haaaa, 16'h5555, 1'b0);
      end
      begin
        tick();
        tick();
        ordy[0] = 1'b0;
        @(negedge clk);
        check("t4_in_ready_c3", ir[0], 0);
        check("t4_valid_c3", ov[0], 1);
        check("t4_hold_c3", sm[0], 16'h0002);
        tick();
        @(negedge clk);
        check("t4_in_ready_c4", ir[0], 0);
        check("t4_hold_c4", sm[0], 16'h0002);
        tick();
        ordy[0] = 1'b1;
      end
    join
    repeat (6) tick();
    check("t4_count", nout[0] - base, 4);
    check("t4_drain", sbq[0].size(), 0);

    send(16'hffff, 16'h0002, 1'b0);
    send(16'h3333, 16'h4444, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check("t5_out_valid", ov[0], 0);
    check("t5_sum", sm[0], 0);
    check("t5_cout", co[0], 0);
    @(negedge clk);
    tick();
    rst  = 1'b0;
    base = nout[0];
    repeat (8) tick();
    check("t5_no_output", nout[0] - base, 0);
    check("t5_idle_valid", ov[0], 0);

    base  = nout[0];
    base1 = nout[1];
    base2 = nout[2];
    sent  = 0;
    for (int n = 0; n < 10000; n++) begin
      a       = 16'($urandom);
      b       = 16'($urandom);
      cin     = 1'($urandom_range(0, 1));
      iv[0]   = ($urandom_range(0, 3) != 0);
      iv[1]   = iv[0];
      iv[2]   = iv[0];
      ordy[0] = ($urandom_range(0, 3) != 0);
      if (iv[0]) sent++;
      tick();
    end
    for (int i = 0; i < 3; i++) iv[i] = 1'b0;
    ordy[0] = 1'b1;
    repeat (12) tick();
    check("t6_count_p1", nout[1] - base1, sent);
    check("t6_count_p4", nout[2] - base2, sent);
    check("t6_progress_p2", (nout[0] - base) > 0, 1);
    for (int i = 0; i < 3; i++) check($sformatf("t6_drain%0d", i), sbq[i].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
